// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester/UART/status bundle for the UART transmit arbiter
//
// Purpose: groups every non-clock signal of uart_tx_arbiter into one bundle.
// Ports (signals):
//   req_valid[N_REQ], req_data[8*N_REQ], req_last[N_REQ] : requester byte streams into the arbiter
//   req_accept[N_REQ]                                    : per-requester byte consumed
//   tx_valid, tx_data[8], tx_accept                      : byte handshake toward the UART core
//   grant_valid, grant_id[GW], timeout_pulse             : lock status
// Modports: slave = arbiter view, master = requesters/UART/monitor view.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 3,
    parameter int GW    = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_accept;
    logic               tx_valid;
    logic [7:0]         tx_data;
    logic               tx_accept;
    logic               grant_valid;
    logic [GW-1:0]      grant_id;
    logic               timeout_pulse;

    modport slave (
        input  req_valid, req_data, req_last, tx_accept,
        output req_accept, tx_valid, tx_data, grant_valid, grant_id, timeout_pulse
    );

    modport master (
        output req_valid, req_data, req_last, tx_accept,
        input  req_accept, tx_valid, tx_data, grant_valid, grant_id, timeout_pulse
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-atomic round-robin arbiter for the UART transmit byte interface
//
// Purpose: shares one UART transmit byte handshake between N_REQ requesters.
// A granted requester keeps the UART until it transfers a byte flagged last,
// or until it leaves valid low for more than TIMEOUT cycles inside a packet.
// Ports:
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : uart_tx_arbiter_if.slave (requester streams, UART handshake, lock status)
module uart_tx_arbiter #(
    parameter int N_REQ   = 3,
    parameter int GW      = 2,
    parameter int TIMEOUT = 1023,
    parameter int TW      = 10
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_arbiter_if.slave   bus
);
    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } state_t;

    state_t        r_state;
    logic [GW-1:0] r_grant_id;
    logic [GW-1:0] r_ptr;
    logic [TW-1:0] r_cnt;
    logic          r_timeout_pulse;

    logic          w_lock;
    logic          w_cur_valid;
    logic          w_cur_last;
    logic [7:0]    w_cur_data;
    logic          w_handshake;
    logic          w_any_valid;
    logic          w_found;
    logic [GW-1:0] w_sel;
    logic [GW-1:0] w_next_ptr;

    assign w_lock      = (r_state == ST_LOCK);
    assign w_any_valid = |bus.req_valid;

    // Lock holder's stream, selected by comparison so that unused grant codes
    // (non-power-of-2 N_REQ) can never index outside the request vectors.
    always_comb begin
        w_cur_valid = 1'b0;
        w_cur_last  = 1'b0;
        w_cur_data  = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant_id == GW'(i)) begin
                w_cur_valid = bus.req_valid[i];
                w_cur_last  = bus.req_last[i];
                w_cur_data  = bus.req_data[8*i +: 8];
            end
        end
    end

    assign w_handshake = w_lock & w_cur_valid & bus.tx_accept;

    // Round-robin search: first valid index among ptr, ptr+1, ... modulo N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_sel   = r_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (!w_found && ((int'(r_ptr) + k) % N_REQ == i) && bus.req_valid[i]) begin
                    w_found = 1'b1;
                    w_sel   = GW'(i);
                end
            end
        end
    end

    assign w_next_ptr = (r_grant_id == GW'(N_REQ - 1)) ? '0 : r_grant_id + GW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_grant_id      <= '0;
            r_ptr           <= '0;
            r_cnt           <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timeout_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_valid) begin
                        r_grant_id <= w_sel;
                        r_state    <= ST_LOCK;
                        r_cnt      <= '0;
                    end
                end
                ST_LOCK: begin
                    if (w_handshake && w_cur_last) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= w_next_ptr;
                    end else if (w_cur_valid) begin
                        // Holder is offering a byte: a UART stall never counts as idle.
                        r_cnt <= '0;
                    end else if (r_cnt == TW'(TIMEOUT)) begin
                        r_state         <= ST_IDLE;
                        r_ptr           <= w_next_ptr;
                        r_cnt           <= '0;
                        r_timeout_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + TW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.req_accept = '0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_accept[i] = w_handshake && (r_grant_id == GW'(i));
        end
    end

    assign bus.tx_valid      = w_lock & w_cur_valid;
    assign bus.tx_data       = w_cur_data;
    assign bus.grant_valid   = w_lock;
    assign bus.grant_id      = r_grant_id;
    assign bus.timeout_pulse = r_timeout_pulse;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit byte interface (valid/data/accept, the same handshake the UART MMIO FIFO presents) between N_REQ byte-stream requesters, e.g. CPU MMIO FIFO, telemetry packer and debug dumper.
- Grants are round-robin and packet-atomic: a granted requester keeps the UART until it transfers a byte flagged last, or until it stalls mid-packet past a timeout.
- Sits between the requesters and the UART transmitter core.

Parameters:
- N_REQ, 3, number of requesters (2..4).
- GW, 2, grant index width, ceil(log2(N_REQ)), minimum 1.
- TIMEOUT, 1023, idle cycles allowed inside a locked packet before forced release.
- TW, 10, timeout counter width; must hold TIMEOUT.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  N_REQ  per-requester byte valid.
- req_data  input  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  input  N_REQ  byte is the final byte of its packet.
- req_accept  output  N_REQ  per-requester byte consumed this cycle.
- tx_valid  output  1  byte offered to the UART core.
- tx_data  output  8  byte to the UART core.
- tx_accept  input  1  UART core consumes tx_data this cycle (only meaningful when tx_valid=1).
- grant_valid  output  1  a requester currently holds the lock.
- grant_id  output  GW  index of the lock holder; valid only when grant_valid=1.
- timeout_pulse  output  1  one-cycle pulse when a lock is force-released.

Behaviour:
- **Reset (rst=1 at a clock edge):**
  - state=IDLE, grant_id=0, priority pointer ptr=0, timeout counter=0, timeout_pulse=0.
  - Combinationally this gives tx_valid=0, req_accept=0 and grant_valid=0.
  - Reset mid-packet drops the lock with no pulse; the next packet starts from ptr=0.
- **States:** IDLE, LOCK. grant_valid = (state==LOCK).
- **IDLE:**
  - If any req_valid is high, select the first valid index searching ptr, ptr+1, … modulo N_REQ.
  - Register it into grant_id, go to LOCK and clear the timeout counter.
  - No byte moves in IDLE, so arbitration costs 1 cycle.
- **LOCK datapath (combinational):**
  - tx_valid = req_valid[grant_id]; tx_data = req_data[grant_id].
  - req_accept[grant_id] = tx_valid & tx_accept; all other req_accept bits are 0.
  - Other requesters' valid bits are ignored.
- **LOCK release by packet end:**
  - Trigger: a handshake (tx_valid & tx_accept) with req_last[grant_id]=1.
  - Next cycle: state=IDLE, ptr=(grant_id+1) mod N_REQ.
  - There is always one idle cycle between packets, even if requests are waiting.
- **LOCK timeout:**
  - The counter increments on each LOCK cycle with req_valid[grant_id]=0.
  - It clears on any cycle with req_valid[grant_id]=1, whether or not tx_accept is high. A UART backpressure stall never times out.
  - When counter==TIMEOUT and req_valid[grant_id]=0: next state IDLE, ptr=(grant_id+1) mod N_REQ, timeout_pulse=1 for exactly one cycle (registered).
  - If a last-byte handshake and the timeout condition fall in the same cycle, the handshake wins and no pulse is raised. This cannot actually happen, since a handshake needs valid=1.
- **Wrap:** ptr and grant_id wrap modulo N_REQ. For non-power-of-2 N_REQ, indices ≥ N_REQ are never produced.
- **Requester contract:** req_data and req_last are held stable while req_valid=1 and not accepted. The arbiter does not check this.
- **Datapath:** the arbiter stores no data (zero buffering, zero latency through LOCK).

Test Plan:
1. Single packet: after reset, req0 sends 0x41,0x42,0x43 (last on 0x43), tx_accept=1 always.
   - grant_valid rises 1 cycle after req_valid0, grant_id=0.
   - tx_data shows 0x41/0x42/0x43 on consecutive cycles, req_accept[0] high 3 cycles.
   - IDLE 1 cycle later.
2. Round-robin: req0, req1 and req2 each continuously offer 2-byte packets.
   - Grant order is 0,1,2,0,1,2 with exactly 1 idle cycle between packets.
   - req_accept is never asserted for a non-holder.
3. Atomicity: while req1 holds mid-packet, req0 and req2 raise valid.
   - No interleaving on tx_data until req1's last byte; next grant_id=2.
4. Backpressure: req0 is locked, tx_accept=0 for 2000 cycles with req_valid0=1.
   - No timeout_pulse, lock held.
   - When tx_accept=1 the byte transfers.
5. Timeout: TIMEOUT=15, req2 sends 1 non-last byte then drops valid.
   - After 16 idle locked cycles, timeout_pulse=1 for 1 cycle and grant_valid=0.
   - A waiting req0 is granted next, since ptr=0.
6. Reset mid-packet: rst=1 for 1 cycle during req1's second byte.
   - Next cycle tx_valid=0, grant_valid=0, no timeout_pulse.
   - With req1 and req2 both valid, grant_id=1 (ptr=0 search).
